// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one master's request/ack channel into the memory arbiter.
//   req/we/addr/wdata : master -> arbiter, held stable until ack
//   ack               : arbiter -> master, one-cycle completion pulse
//   rdata             : arbiter -> master, read data held until next read completes
interface mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter/sequencer for a single synchronous memory.
//   clk, RSTN           : clock, asynchronous active-low reset
//   m0, m1              : master channels (m0 = CPU memory stage, m1 = debug port)
//   mem_en/we/addr/wdata: registered memory strobe and access fields
//   mem_rdata           : memory read data, valid MEM_LAT cycles after mem_en
//   busy, owner         : arbiter not idle / index of the granted master
module mem_arbiter #(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1,
    parameter bit PRIO_M0 = 1'b0
) (
    input  logic           clk,
    input  logic           RSTN,
    mem_arbiter_if.slave   m0,
    mem_arbiter_if.slave   m1,
    output logic           mem_en,
    output logic           mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic [DW-1:0]  mem_rdata,
    output logic           busy,
    output logic           owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);
    state_t     state;
    logic       last;
    logic [2:0] cnt;
    logic       win;
    logic       go_ack;
    // Master 1 wins only when alone, or on contention under round-robin after master 0 was last served.
    assign win = m1.req & (~m0.req | (~PRIO_M0 & ~last));
    // Ack is registered, so it is raised on the transition into ACK.
    assign go_ack = (state == ISSUE && MEM_LAT == 1) || (state == WAIT && cnt == 3'd1);
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            last      <= 1'b1;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0.ack    <= 1'b0;
            m1.ack    <= 1'b0;
            m0.rdata  <= '0;
            m1.rdata  <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            m0.ack <= go_ack & ~owner;
            m1.ack <= go_ack & owner;
            case (state)
                IDLE: if (m0.req | m1.req) begin
                    owner     <= win;
                    last      <= win;
                    mem_we    <= win ? m1.we : m0.we;
                    mem_addr  <= win ? m1.addr : m0.addr;
                    mem_wdata <= win ? m1.wdata : m0.wdata;
                    mem_en    <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    cnt    <= CNT_INIT;
                    state  <= (MEM_LAT > 1) ? WAIT : ACK;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) state <= ACK;
                end
                ACK: begin
                    if (!mem_we && owner) m1.rdata <= mem_rdata;
                    if (!mem_we && !owner) m0.rdata <= mem_rdata;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (RR lat 1, fixed-prio lat 1, RR lat 3).
module tb_mem_arbiter;
    localparam int N = 3;
    localparam int LATS [N] = '{1, 1, 3};
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rstn [N];
    logic        req [N][2];
    logic        we [N][2];
    logic [9:0]  addr [N][2];
    logic [31:0] wdata [N][2];
    logic        ack [N][2];
    logic [31:0] rdata [N][2];
    logic        mem_en [N];
    logic        mem_we [N];
    logic        busy [N];
    logic        owner [N];
    logic [9:0]  mem_addr [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    typedef struct { int inst; int mst; logic [31:0] data; } exp_t;
    exp_t        sb [$];
    logic [31:0] shadow [N][1024];
    logic [31:0] exp_rd [N][2];
    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [31:0] init_word(logic [9:0] a);
        return (a == 10'h004) ? 32'h8C01_0014 : {22'h2A5A5A, a};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT = LATS[g];
        mem_arbiter_if #(.AW(10), .DW(32)) m0_if ();
        mem_arbiter_if #(.AW(10), .DW(32)) m1_if ();
        bit          wr [1024];
        logic [31:0] mem [1024];
        bit [LAT-1:0] pv;
        logic [31:0] pd [LAT];
        assign m0_if.req   = req[g][0];
        assign m0_if.we    = we[g][0];
        assign m0_if.addr  = addr[g][0];
        assign m0_if.wdata = wdata[g][0];
        assign m1_if.req   = req[g][1];
        assign m1_if.we    = we[g][1];
        assign m1_if.addr  = addr[g][1];
        assign m1_if.wdata = wdata[g][1];
        assign ack[g][0]   = m0_if.ack;
        assign ack[g][1]   = m1_if.ack;
        assign rdata[g][0] = m0_if.rdata;
        assign rdata[g][1] = m1_if.rdata;
        mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(LAT), .PRIO_M0(g == 1)) u_dut (
            .clk       (clk),
            .RSTN      (rstn[g]),
            .m0        (m0_if),
            .m1        (m1_if),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g]),
            .owner     (owner[g])
        );
        // Memory model: read data is valid only in the single cycle LAT after mem_en.
        always @(posedge clk) begin
            if (mem_en[g] && mem_we[g]) begin
                mem[mem_addr[g]] <= mem_wdata[g];
                wr[mem_addr[g]]  <= 1'b1;
            end
            pv[0] <= mem_en[g] && !mem_we[g];
            pd[0] <= wr[mem_addr[g]] ? mem[mem_addr[g]] : init_word(mem_addr[g]);
            for (int k = 1; k < LAT; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
        assign mem_rdata[g] = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_0BAD;
    end

    function automatic logic [31:0] outs_nz(int i);
        return 32'(mem_en[i] | mem_we[i] | (|mem_addr[i]) | (|mem_wdata[i]) | ack[i][0] | ack[i][1]
                   | (|rdata[i][0]) | (|rdata[i][1]) | busy[i] | owner[i]);
    endfunction

    task automatic expect_txn(int i, int m, bit w, logic [9:0] a, logic [31:0] d);
        if (w) shadow[i][a] = d;
        else exp_rd[i][m] = shadow[i][a];
        sb.push_back('{inst: i, mst: m, data: exp_rd[i][m]});
    endtask

    task automatic drive(int i, int m, bit w, logic [9:0] a, logic [31:0] d);
        req[i][m] = 1'b1;
        we[i][m] = w;
        addr[i][m] = a;
        wdata[i][m] = d;
    endtask

    task automatic txn(int i, int m, bit w, logic [9:0] a, logic [31:0] d);
        int n = 0;
        int en = 0;
        int oth = 0;
        bit done = 0;
        @(negedge clk);
        expect_txn(i, m, w, a, d);
        drive(i, m, w, a, d);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            chk("busy", 32'(busy[i]), 1);
            chk("owner", 32'(owner[i]), m);
            if (mem_en[i]) begin
                en++;
                chk("mem_addr", 32'(mem_addr[i]), 32'(a));
                chk("mem_we", 32'(mem_we[i]), 32'(w));
                if (w) chk("mem_wdata", mem_wdata[i], d);
            end
            if (ack[i][1-m]) oth++;
            if (ack[i][m]) done = 1;
        end
        req[i][m] = 1'b0;
        chk("ack_lat", n, LATS[i] + 1);
        chk("mem_en_once", en, 1);
        chk("other_ack", oth, 0);
    endtask

    task automatic contend(int i, int n0, int n1, output int cyc, output int idle);
        int c [2] = '{0, 0};
        @(negedge clk);
        drive(i, 0, 0, 10'h010, 0);
        drive(i, 1, 0, 10'h020, 0);
        cyc = 0;
        idle = 0;
        while ((c[0] < n0 || c[1] < n1) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!busy[i]) idle++;
            for (int m = 0; m < 2; m++) if (ack[i][m]) begin
                c[m]++;
                if (c[m] >= (m == 0 ? n0 : n1)) req[i][m] = 1'b0;
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        bit pend = 0;
        int pi, pm;
        logic [31:0] pdat;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("rdata", rdata[pi][pm], pdat);
                pend = 0;
            end
            for (int i = 0; i < N; i++) for (int m = 0; m < 2; m++) if (ack[i][m]) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ack_inst", i, e.inst);
                    chk("ack_master", m, e.mst);
                    pend = 1;
                    pi = i;
                    pm = m;
                    pdat = e.data;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int cyc, idle;
        for (int i = 0; i < N; i++) begin
            rstn[i] = 1'b0;
            for (int m = 0; m < 2; m++) begin
                req[i][m] = 1'b0;
                we[i][m] = 1'b0;
                addr[i][m] = '0;
                wdata[i][m] = '0;
                exp_rd[i][m] = '0;
            end
            for (int a = 0; a < 1024; a++) shadow[i][a] = init_word(10'(a));
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) chk("reset_outputs", outs_nz(i), 0);
        for (int i = 0; i < N; i++) rstn[i] = 1'b1;
        txn(0, 0, 0, 10'h004, 32'h0);
        txn(0, 1, 1, 10'h3FF, 32'hDEAD_BEEF);
        txn(0, 0, 0, 10'h3FF, 32'h0);
        @(negedge clk);
        rstn[0] = 1'b0;
        exp_rd[0][0] = '0;
        exp_rd[0][1] = '0;
        repeat (2) @(negedge clk);
        chk("reset2_outputs", outs_nz(0), 0);
        rstn[0] = 1'b1;
        for (int k = 0; k < 4; k++) expect_txn(0, k % 2, 0, k % 2 ? 10'h020 : 10'h010, 0);
        contend(0, 2, 2, cyc, idle);
        chk("rr_cycles", cyc, 11);
        chk("rr_idle", idle, 3);
        for (int k = 0; k < 4; k++) expect_txn(1, k / 3, 0, k / 3 ? 10'h020 : 10'h010, 0);
        contend(1, 3, 1, cyc, idle);
        chk("prio_cycles", cyc, 11);
        chk("prio_idle", idle, 3);
        txn(2, 0, 0, 10'h123, 32'h0);
        txn(2, 1, 1, 10'h123, 32'h1234_5678);
        txn(2, 1, 0, 10'h123, 32'h0);
        @(negedge clk);
        drive(2, 1, 0, 10'h050, 0);
        repeat (2) @(negedge clk);
        chk("wait_busy", 32'(busy[2]), 1);
        #1;
        rstn[2] = 1'b0;
        req[2][1] = 1'b0;
        exp_rd[2][0] = '0;
        exp_rd[2][1] = '0;
        #1;
        chk("async_reset_outputs", outs_nz(2), 0);
        repeat (3) @(negedge clk);
        chk("reset_held_outputs", outs_nz(2), 0);
        rstn[2] = 1'b1;
        expect_txn(2, 0, 0, 10'h010, 0);
        expect_txn(2, 1, 0, 10'h020, 0);
        contend(2, 1, 1, cyc, idle);
        chk("post_reset_cycles", cyc, 9);
        chk("post_reset_idle", idle, 1);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
